// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues word fetches to a synchronous
// instruction memory, buffers returned words in a 2-entry queue and hands one
// instruction plus its PC+4 per cycle to decode over a valid/ready handshake.
// Optional feature macro: IFU_FETCH_COUNT_EN adds a 16-bit delivered-instruction
// counter on fetch_count_o.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_plus4_o
`ifdef IFU_FETCH_COUNT_EN
    ,
    output logic [15:0] fetch_count_o
`endif
);

    localparam logic [1:0] QDEPTH_L = QDEPTH[1:0];

    logic [31:0] r_fetch_pc;
    logic [31:0] r_pend_pc4;   // PC+4 of the word currently in flight
    logic [31:0] r_q_instr [2];
    logic [31:0] r_q_pc4   [2];
    logic        r_head;
    logic [1:0]  r_cnt;
    logic        r_inflight;

    logic        w_pop;
    logic        w_push;
    logic        w_issue;
    logic        w_tail;
    logic [1:0]  w_used;
    logic        w_unused;

    // Redirect targets are forced word aligned, so the low bits are dropped.
    assign w_unused = ^redirect_pc_i[1:0];

    // Handshake, push and issue decisions for this cycle.
    always_comb begin
        w_pop   = (r_cnt != 2'd0) && instr_ready_i;
        w_push  = r_inflight && !redirect_i;
        w_used  = r_cnt + {1'b0, r_inflight};
        // A pop this cycle frees a slot, so issue may proceed even when full.
        w_issue = !rst_i && !redirect_i && ((w_used < QDEPTH_L) || w_pop);
        // Tail slot is head + cnt modulo 2.
        w_tail  = r_head ^ r_cnt[0];
    end

    // PC, queue and in-flight tracking; redirect flushes all younger work.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_pc <= RESET_PC;
            r_pend_pc4 <= 32'h0;
            r_head     <= 1'b0;
            r_cnt      <= 2'd0;
            r_inflight <= 1'b0;
        end else if (redirect_i) begin
            r_fetch_pc <= {redirect_pc_i[31:2], 2'b00};
            r_cnt      <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_pend_pc4 <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
                r_q_instr[w_tail] <= imem_data_i;
                r_q_pc4[w_tail]   <= r_pend_pc4;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef IFU_FETCH_COUNT_EN
    logic [15:0] r_fetch_count;

    // Delivered-instruction count; a pop in a redirect cycle is the branch itself.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_count <= 16'h0;
        end else if (w_pop) begin
            r_fetch_count <= r_fetch_count + 16'd1;
        end
    end

    assign fetch_count_o = r_fetch_count;
`endif

    // Outputs derived from registered state only (except the request strobe).
    always_comb begin
        imem_req_o    = w_issue;
        imem_addr_o   = r_fetch_pc;
        instr_valid_o = (r_cnt != 2'd0);
        instr_o       = instr_valid_o ? r_q_instr[r_head] : 32'h0;
        pc_plus4_o    = instr_valid_o ? r_q_pc4[r_head] : 32'h0;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. Instance A runs from PC 0, instance B
// starts near the top of the address space to exercise PC wrap. Memory word at
// byte address a is a >> 2.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A signals
    logic        rst_a = 1'b1, redir_a = 1'b0, ready_a = 1'b0;
    logic [31:0] rpc_a = 32'h0, data_a;
    logic        req_a, valid_a;
    logic [31:0] addr_a, instr_a, pc4_a;
    logic [15:0] cnt_a;

    // Instance B signals
    logic        rst_b = 1'b1, redir_b = 1'b0, ready_b = 1'b0;
    logic [31:0] rpc_b = 32'h0, data_b;
    logic        req_b, valid_b;
    logic [31:0] addr_b, instr_b, pc4_b;
    logic [15:0] cnt_b;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) u_dut_a (
        .clk_i         (clk),
        .rst_i         (rst_a),
        .imem_req_o    (req_a),
        .imem_addr_o   (addr_a),
        .imem_data_i   (data_a),
        .redirect_i    (redir_a),
        .redirect_pc_i (rpc_a),
        .instr_valid_o (valid_a),
        .instr_ready_i (ready_a),
        .instr_o       (instr_a),
        .pc_plus4_o    (pc4_a)
`ifdef IFU_FETCH_COUNT_EN
        ,
        .fetch_count_o (cnt_a)
`endif
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) u_dut_b (
        .clk_i         (clk),
        .rst_i         (rst_b),
        .imem_req_o    (req_b),
        .imem_addr_o   (addr_b),
        .imem_data_i   (data_b),
        .redirect_i    (redir_b),
        .redirect_pc_i (rpc_b),
        .instr_valid_o (valid_b),
        .instr_ready_i (ready_b),
        .instr_o       (instr_b),
        .pc_plus4_o    (pc4_b)
`ifdef IFU_FETCH_COUNT_EN
        ,
        .fetch_count_o (cnt_b)
`endif
    );

`ifndef IFU_FETCH_COUNT_EN
    assign cnt_a = 16'h0;
    assign cnt_b = 16'h0;
`endif

    // Synchronous memories: data valid exactly one cycle after the request.
    always @(posedge clk) data_a <= req_a ? (addr_a >> 2) : 32'hDEAD_BEEF;
    always @(posedge clk) data_b <= req_b ? (addr_b >> 2) : 32'hDEAD_BEEF;

    function automatic logic [97:0] pack(input logic v, input logic [31:0] ins,
                                         input logic [31:0] p4, input logic rq,
                                         input logic [31:0] ad);
        return {v, ins, p4, rq, ad};
    endfunction

    // Drive A's inputs at the falling edge, then settle before sampling.
    task automatic cyc(input logic rst, input logic redir, input logic [31:0] rpc,
                       input logic rdy);
        @(negedge clk);
        rst_a   = rst;
        redir_a = redir;
        rpc_a   = rpc;
        ready_a = rdy;
        #1;
    endtask

    task automatic test_reset;
        logic [97:0] exp;
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        total++;
        if (pack(valid_a, instr_a, pc4_a, req_a, addr_a) !== pack(1'b0, 0, 0, 1'b0, 0)) begin
            bad++;
            $display("FAIL reset_state got v=%b i=%h p=%h rq=%b a=%h want all 0",
                     valid_a, instr_a, pc4_a, req_a, addr_a);
        end
`ifdef IFU_FETCH_COUNT_EN
        total++;
        if (cnt_a !== 16'd0) begin
            bad++;
            $display("FAIL reset_count got %0d want 0", cnt_a);
        end
`endif
        for (int c = 0; c < 8; c++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1);
            exp = pack(c >= 2, (c >= 2) ? 32'(c - 2) : 32'h0,
                       (c >= 2) ? 32'(4 * (c - 1)) : 32'h0, 1'b1, 32'(4 * c));
            total++;
            if (pack(valid_a, instr_a, pc4_a, req_a, addr_a) !== exp) begin
                bad++;
                $display("FAIL stream c=%0d got %h want %h", c,
                         pack(valid_a, instr_a, pc4_a, req_a, addr_a), exp);
            end
`ifdef IFU_FETCH_COUNT_EN
            total++;
            if (cnt_a !== ((c >= 2) ? 16'(c - 2) : 16'd0)) begin
                bad++;
                $display("FAIL stream_count c=%0d got %0d", c, cnt_a);
            end
`endif
        end
    endtask

    task automatic test_backpressure;
        logic [97:0] exp;
        for (int c = 8; c < 13; c++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b0);
            exp = pack(1'b1, 32'd6, 32'd28, 1'b0, 32'd32);
            total++;
            if (pack(valid_a, instr_a, pc4_a, req_a, addr_a) !== exp) begin
                bad++;
                $display("FAIL stall c=%0d got %h want %h", c,
                         pack(valid_a, instr_a, pc4_a, req_a, addr_a), exp);
            end
        end
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1);
            exp = pack(1'b1, 32'(6 + k), 32'(4 * (7 + k)), 1'b1, 32'(32 + 4 * k));
            total++;
            if (pack(valid_a, instr_a, pc4_a, req_a, addr_a) !== exp) begin
                bad++;
                $display("FAIL resume k=%0d got %h want %h", k,
                         pack(valid_a, instr_a, pc4_a, req_a, addr_a), exp);
            end
        end
`ifdef IFU_FETCH_COUNT_EN
        total++;
        if (cnt_a !== 16'd10) begin
            bad++;
            $display("FAIL resume_count got %0d want 10", cnt_a);
        end
`endif
    endtask

    task automatic test_redirect_flush;
        logic [97:0] exp [4];
        exp[0] = pack(1'b1, 32'd11, 32'd48, 1'b0, 32'd52);
        exp[1] = pack(1'b0, 32'd0, 32'd0, 1'b1, 32'h40);
        exp[2] = pack(1'b0, 32'd0, 32'd0, 1'b1, 32'h44);
        exp[3] = pack(1'b1, 32'd16, 32'h44, 1'b1, 32'h48);
        for (int k = 0; k < 4; k++) begin
            if (k == 0) cyc(1'b0, 1'b1, 32'h0000_0040, 1'b0);
            else        cyc(1'b0, 1'b0, 32'h0, 1'b1);
            total++;
            if (pack(valid_a, instr_a, pc4_a, req_a, addr_a) !== exp[k]) begin
                bad++;
                $display("FAIL redirect_flush k=%0d got %h want %h", k,
                         pack(valid_a, instr_a, pc4_a, req_a, addr_a), exp[k]);
            end
`ifdef IFU_FETCH_COUNT_EN
            if (k == 0) begin
                total++;
                if (cnt_a !== 16'd11) begin
                    bad++;
                    $display("FAIL redirect_flush_count got %0d want 11", cnt_a);
                end
            end
`endif
        end
    endtask

    task automatic test_redirect_pop;
        logic [97:0] exp [4];
        exp[0] = pack(1'b1, 32'd17, 32'h48, 1'b0, 32'h4C);
        exp[1] = pack(1'b0, 32'd0, 32'd0, 1'b1, 32'h40);
        exp[2] = pack(1'b0, 32'd0, 32'd0, 1'b1, 32'h44);
        exp[3] = pack(1'b1, 32'd16, 32'h44, 1'b1, 32'h48);
        for (int k = 0; k < 4; k++) begin
            if (k == 0) cyc(1'b0, 1'b1, 32'h0000_0043, 1'b1);
            else        cyc(1'b0, 1'b0, 32'h0, 1'b1);
            total++;
            if (pack(valid_a, instr_a, pc4_a, req_a, addr_a) !== exp[k]) begin
                bad++;
                $display("FAIL redirect_pop k=%0d got %h want %h", k,
                         pack(valid_a, instr_a, pc4_a, req_a, addr_a), exp[k]);
            end
`ifdef IFU_FETCH_COUNT_EN
            if (k < 2) begin
                total++;
                if (cnt_a !== 16'(12 + k)) begin
                    bad++;
                    $display("FAIL redirect_pop_count k=%0d got %0d want %0d", k, cnt_a, 12 + k);
                end
            end
`endif
        end
    endtask

    task automatic test_reset_mid;
        logic [97:0] exp [4];
        exp[0] = pack(1'b1, 32'd17, 32'h48, 1'b0, 32'h4C);
        exp[1] = pack(1'b1, 32'd17, 32'h48, 1'b0, 32'h4C);
        exp[2] = pack(1'b0, 32'd0, 32'd0, 1'b0, 32'h0);
        exp[3] = pack(1'b0, 32'd0, 32'd0, 1'b1, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cyc((k == 1) || (k == 2), 1'b0, 32'h0, k == 3);
            total++;
            if (pack(valid_a, instr_a, pc4_a, req_a, addr_a) !== exp[k]) begin
                bad++;
                $display("FAIL reset_mid k=%0d got %h want %h", k,
                         pack(valid_a, instr_a, pc4_a, req_a, addr_a), exp[k]);
            end
`ifdef IFU_FETCH_COUNT_EN
            if (k == 1 || k == 2) begin
                total++;
                if (cnt_a !== ((k == 1) ? 16'd14 : 16'd0)) begin
                    bad++;
                    $display("FAIL reset_mid_count k=%0d got %0d", k, cnt_a);
                end
            end
`endif
        end
    endtask

    task automatic test_wrap;
        logic [97:0] exp [6];
        exp[0] = pack(1'b0, 32'h0, 32'h0, 1'b0, 32'hFFFF_FFF8);
        exp[1] = pack(1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFF8);
        exp[2] = pack(1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        exp[3] = pack(1'b1, 32'h3FFF_FFFE, 32'hFFFF_FFFC, 1'b1, 32'h0);
        exp[4] = pack(1'b1, 32'h3FFF_FFFF, 32'h0, 1'b1, 32'h4);
        exp[5] = pack(1'b1, 32'h0, 32'h4, 1'b1, 32'h8);
        @(negedge clk);
        rst_b   = 1'b1;
        ready_b = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rst_b = (k == 0);
            #1;
            total++;
            if (pack(valid_b, instr_b, pc4_b, req_b, addr_b) !== exp[k]) begin
                bad++;
                $display("FAIL wrap k=%0d got %h want %h", k,
                         pack(valid_b, instr_b, pc4_b, req_b, addr_b), exp[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_redirect_flush();
        test_redirect_pop();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
